// File: rtl/noc_pkg.sv
// Shared NoC types and width helpers for endpoints, credit counters and routers.
package noc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } tx_state_e;

   // Bits needed to hold the values 0..max_val inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

   // Sequence field occupies everything below the source-id field.
   function automatic int unsigned seq_width(input int unsigned flit_w, input int unsigned dest_w);
      return flit_w - dest_w;
   endfunction

   // LSB position of the source-id field in a flit.
   function automatic int unsigned src_lsb(input int unsigned flit_w, input int unsigned dest_w);
      return flit_w - dest_w;
   endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for one downstream buffer: issue consumes, credit_in returns.
module noc_credit_counter
   import noc_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned INIT  = DEPTH,
   localparam int unsigned CW    = cnt_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          issue,
   input  logic          credit_in,
   output logic          has_credit,
   output logic [CW-1:0] count
);

   logic          w_issue_ok;
   logic          w_overflow;
   logic [CW-1:0] w_count_nxt;

   // A returned credit cannot fund an issue in the same cycle.
   always_comb begin
      w_issue_ok  = issue && (count != '0);
      w_overflow  = credit_in && !w_issue_ok && (count == CW'(DEPTH));
      w_count_nxt = count;
      if (w_issue_ok && !credit_in) begin
         w_count_nxt = count - CW'(1);
      end else if (!w_issue_ok && credit_in && !w_overflow) begin
         w_count_nxt = count + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= CW'(INIT);
         has_credit <= (INIT != 0);
      end else begin
         count      <= w_count_nxt;
         has_credit <= (w_count_nxt != '0);
      end
   end

   a_no_credit_overflow : assert property (@(posedge clk) disable iff (!rst_n) !w_overflow);

endmodule

// File: rtl/noc_traffic_endpoint.sv
// Credit-based multi-flit packet generator plus in-order receive checker for one
// router port pair.
module noc_traffic_endpoint
   import noc_pkg::*;
#(
   parameter  int unsigned NOC_NUM_ENDPOINTS = 2,
   parameter  int unsigned DEST_WIDTH        = 1,
   parameter  int unsigned FLIT_WIDTH        = 32,
   parameter  int unsigned FLIT_BUFFER_DEPTH = 4,
   parameter  int unsigned MAX_PKT_LEN       = 8,
   parameter  int unsigned ENDPOINT_ID       = 0,
   localparam int unsigned LEN_W             = cnt_width(MAX_PKT_LEN),
   localparam int unsigned SEQ_W             = seq_width(FLIT_WIDTH, DEST_WIDTH),
   localparam int unsigned CRD_W             = cnt_width(FLIT_BUFFER_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_enable,
   input  logic                  cfg_dest_mode,
   input  logic [DEST_WIDTH-1:0] cfg_dest,
   input  logic [LEN_W-1:0]      cfg_pkt_len,
   input  logic [15:0]           cfg_num_pkts,
   output logic [FLIT_WIDTH-1:0] data_out,
   output logic [DEST_WIDTH-1:0] dest_out,
   output logic                  is_tail_out,
   output logic                  send_out,
   input  logic                  credit_in,
   input  logic [FLIT_WIDTH-1:0] data_in,
   input  logic [DEST_WIDTH-1:0] dest_in,
   input  logic                  is_tail_in,
   input  logic                  send_in,
   output logic                  credit_out,
   output logic                  tx_done,
   output logic [15:0]           tx_pkt_count,
   output logic [15:0]           rx_pkt_count,
   output logic                  err_seq,
   output logic                  err_dest
);

   localparam int unsigned           NDEST     = 1 << DEST_WIDTH;
   localparam int unsigned           SRC_LSB   = src_lsb(FLIT_WIDTH, DEST_WIDTH);
   localparam logic [DEST_WIDTH-1:0] MY_ID     = DEST_WIDTH'(ENDPOINT_ID);
   localparam logic [DEST_WIDTH-1:0] LAST_DEST = DEST_WIDTH'(NOC_NUM_ENDPOINTS - 1);

   tx_state_e             r_state;
   logic [LEN_W-1:0]      r_len;
   logic [LEN_W-1:0]      r_flit_idx;
   logic [DEST_WIDTH-1:0] r_dest;
   logic [SEQ_W-1:0]      r_tx_seq [NDEST];
   logic [SEQ_W-1:0]      r_rx_exp [NDEST];
   logic [FLIT_WIDTH-1:0] r_data_out;
   logic [DEST_WIDTH-1:0] r_dest_out;
   logic                  r_tail_out;
   logic                  r_send_out;
   logic                  r_credit_out;
   logic                  r_tx_done;
   logic [15:0]           r_tx_pkt_cnt;
   logic [15:0]           r_rx_pkt_cnt;
   logic                  r_err_seq;
   logic                  r_err_dest;

   tx_state_e             w_state_nxt;
   logic [LEN_W-1:0]      w_len_nxt;
   logic [LEN_W-1:0]      w_idx_nxt;
   logic [DEST_WIDTH-1:0] w_dest_nxt;
   logic [15:0]           w_pkt_cnt_nxt;
   logic [LEN_W-1:0]      w_len_eff;
   logic [DEST_WIDTH-1:0] w_dest_adv;
   logic                  w_more;
   logic                  w_issue;
   logic                  w_is_tail;
   logic                  w_has_credit;
   logic [CRD_W-1:0]      w_credit_cnt;
   logic [SEQ_W-1:0]      w_tx_seq_cur;
   logic [DEST_WIDTH-1:0] w_rx_src;
   logic [SEQ_W-1:0]      w_rx_seq;
   logic                  w_rx_src_bad;

   noc_credit_counter #(
      .DEPTH (FLIT_BUFFER_DEPTH),
      .INIT  (FLIT_BUFFER_DEPTH)
   ) u_credit (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue      (w_issue),
      .credit_in  (credit_in),
      .has_credit (w_has_credit),
      .count      (w_credit_cnt)
   );

   // Packet length clamp, destination sweep and issue qualification.
   always_comb begin
      if (cfg_pkt_len == '0) begin
         w_len_eff = LEN_W'(1);
      end else if (32'(cfg_pkt_len) > MAX_PKT_LEN) begin
         w_len_eff = LEN_W'(MAX_PKT_LEN);
      end else begin
         w_len_eff = cfg_pkt_len;
      end
      w_dest_adv   = (r_dest == LAST_DEST) ? '0 : r_dest + DEST_WIDTH'(1);
      w_more       = (cfg_num_pkts == 16'd0) || (r_tx_pkt_cnt < cfg_num_pkts);
      w_issue      = (r_state == SEND) && w_has_credit;
      w_is_tail    = (r_flit_idx == r_len);
      w_tx_seq_cur = r_tx_seq[r_dest];
   end

   // TX next-state logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_len_nxt     = r_len;
      w_idx_nxt     = r_flit_idx;
      w_dest_nxt    = r_dest;
      w_pkt_cnt_nxt = r_tx_pkt_cnt;
      case (r_state)
         IDLE: begin
            if (cfg_enable && w_more) begin
               w_state_nxt = SEND;
               w_len_nxt   = w_len_eff;
               w_idx_nxt   = LEN_W'(1);
               w_dest_nxt  = cfg_dest;
            end
         end
         SEND: begin
            if (w_issue) begin
               if (w_is_tail) begin
                  w_pkt_cnt_nxt = r_tx_pkt_cnt + 16'd1;
                  w_len_nxt     = w_len_eff;
                  w_idx_nxt     = LEN_W'(1);
                  w_dest_nxt    = cfg_dest_mode ? w_dest_adv : cfg_dest;
                  if ((cfg_num_pkts != 16'd0) && (w_pkt_cnt_nxt == cfg_num_pkts)) begin
                     w_state_nxt = DONE;
                  end else if (!cfg_enable) begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_idx_nxt = r_flit_idx + LEN_W'(1);
               end
            end
         end
         DONE: begin
            if (!cfg_enable) begin
               w_state_nxt   = IDLE;
               w_pkt_cnt_nxt = 16'd0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_len        <= LEN_W'(1);
         r_flit_idx   <= LEN_W'(1);
         r_dest       <= '0;
         r_tx_pkt_cnt <= 16'd0;
         r_tx_done    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_len        <= w_len_nxt;
         r_flit_idx   <= w_idx_nxt;
         r_dest       <= w_dest_nxt;
         r_tx_pkt_cnt <= w_pkt_cnt_nxt;
         r_tx_done    <= (w_state_nxt == DONE);
      end
   end

   // Flit launch: one registered flit per issue, per-destination sequence stamp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out <= '0;
         r_dest_out <= '0;
         r_tail_out <= 1'b0;
         r_send_out <= 1'b0;
         for (int i = 0; i < NDEST; i++) begin
            r_tx_seq[i] <= SEQ_W'(1);
         end
      end else begin
         r_send_out <= w_issue;
         r_tail_out <= w_issue && w_is_tail;
         if (w_issue) begin
            r_data_out       <= {MY_ID, w_tx_seq_cur};
            r_dest_out       <= r_dest;
            r_tx_seq[r_dest] <= w_tx_seq_cur + SEQ_W'(1);
         end
      end
   end

   always_comb begin
      w_rx_src     = data_in[SRC_LSB +: DEST_WIDTH];
      w_rx_seq     = data_in[SEQ_W-1:0];
      w_rx_src_bad = (32'(w_rx_src) >= NOC_NUM_ENDPOINTS);
   end

   // RX checker; expected sequence always resyncs to the received value + 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credit_out <= 1'b0;
         r_rx_pkt_cnt <= 16'd0;
         r_err_seq    <= 1'b0;
         r_err_dest   <= 1'b0;
         for (int i = 0; i < NDEST; i++) begin
            r_rx_exp[i] <= SEQ_W'(1);
         end
      end else begin
         r_credit_out <= send_in;
         if (send_in) begin
            r_rx_exp[w_rx_src] <= w_rx_seq + SEQ_W'(1);
            if (w_rx_src_bad || (w_rx_seq != r_rx_exp[w_rx_src])) begin
               r_err_seq <= 1'b1;
            end
            if (dest_in != MY_ID) begin
               r_err_dest <= 1'b1;
            end
            if (is_tail_in) begin
               r_rx_pkt_cnt <= r_rx_pkt_cnt + 16'd1;
            end
         end
      end
   end

   a_credit_flag_consistent : assert property (@(posedge clk) disable iff (!rst_n)
      w_has_credit == (w_credit_cnt != '0));

   assign data_out     = r_data_out;
   assign dest_out     = r_dest_out;
   assign is_tail_out  = r_tail_out;
   assign send_out     = r_send_out;
   assign credit_out   = r_credit_out;
   assign tx_done      = r_tx_done;
   assign tx_pkt_count = r_tx_pkt_cnt;
   assign rx_pkt_count = r_rx_pkt_cnt;
   assign err_seq      = r_err_seq;
   assign err_dest     = r_err_dest;

endmodule

// File: tb/tb_noc_traffic_endpoint.sv
// Directed bench for noc_traffic_endpoint: 4-endpoint config, endpoint 0.
module tb_noc_traffic_endpoint;

   localparam int unsigned NE  = 4;
   localparam int unsigned DW  = 2;
   localparam int unsigned FW  = 32;
   localparam int unsigned BD  = 4;
   localparam int unsigned MPL = 8;
   localparam int unsigned LW  = 4;

   typedef struct packed {
      logic [FW-1:0] d;
      logic [DW-1:0] dst;
      logic          tl;
   } flit_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_enable = 1'b0;
   logic          cfg_dest_mode = 1'b0;
   logic [DW-1:0] cfg_dest = '0;
   logic [LW-1:0] cfg_pkt_len = '0;
   logic [15:0]   cfg_num_pkts = '0;
   logic [FW-1:0] data_out;
   logic [DW-1:0] dest_out;
   logic          is_tail_out;
   logic          send_out;
   logic          credit_in = 1'b0;
   logic [FW-1:0] data_in = '0;
   logic [DW-1:0] dest_in = '0;
   logic          is_tail_in = 1'b0;
   logic          send_in = 1'b0;
   logic          credit_out;
   logic          tx_done;
   logic [15:0]   tx_pkt_count;
   logic [15:0]   rx_pkt_count;
   logic          err_seq;
   logic          err_dest;

   int    n_vec = 0;
   int    n_err = 0;
   logic  loopback = 1'b0;
   flit_t fq[$];

   noc_traffic_endpoint #(
      .NOC_NUM_ENDPOINTS (NE),
      .DEST_WIDTH        (DW),
      .FLIT_WIDTH        (FW),
      .FLIT_BUFFER_DEPTH (BD),
      .MAX_PKT_LEN       (MPL),
      .ENDPOINT_ID       (0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_enable    (cfg_enable),
      .cfg_dest_mode (cfg_dest_mode),
      .cfg_dest      (cfg_dest),
      .cfg_pkt_len   (cfg_pkt_len),
      .cfg_num_pkts  (cfg_num_pkts),
      .data_out      (data_out),
      .dest_out      (dest_out),
      .is_tail_out   (is_tail_out),
      .send_out      (send_out),
      .credit_in     (credit_in),
      .data_in       (data_in),
      .dest_in       (dest_in),
      .is_tail_in    (is_tail_in),
      .send_in       (send_in),
      .credit_out    (credit_out),
      .tx_done       (tx_done),
      .tx_pkt_count  (tx_pkt_count),
      .rx_pkt_count  (rx_pkt_count),
      .err_seq       (err_seq),
      .err_dest      (err_dest)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   // Advance one clock, sample just after the edge, log flits, loop credits back.
   task automatic tick();
      @(posedge clk);
      #1;
      if (send_out) fq.push_back('{d: data_out, dst: dest_out, tl: is_tail_out});
      if (loopback) credit_in = send_out;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      loopback      = 1'b0;
      credit_in     = 1'b0;
      cfg_enable    = 1'b0;
      cfg_dest_mode = 1'b0;
      send_in       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      fq.delete();
   endtask

   task automatic rx_flit(input logic [DW-1:0] src, input int seq, input logic [DW-1:0] dst,
                          input logic tail);
      data_in    = {src, 30'(seq)};
      dest_in    = dst;
      is_tail_in = tail;
      send_in    = 1'b1;
      tick();
      send_in    = 1'b0;
   endtask

   initial begin
      int exp_d[10];
      int exp_s[10];
      int nflit;
      int bad;
      int base;
      exp_d = '{2, 2, 3, 3, 0, 0, 1, 1, 2, 2};
      exp_s = '{1, 2, 1, 2, 1, 2, 1, 2, 3, 4};

      // Reset state
      do_reset();
      check("rst send_out", 32'(send_out), 32'd0);
      check("rst data_out", data_out, 32'd0);
      check("rst tx_done", 32'(tx_done), 32'd0);
      check("rst tx_pkt_count", 32'(tx_pkt_count), 32'd0);
      check("rst credit_out", 32'(credit_out), 32'd0);
      check("rst err flags", 32'({err_seq, err_dest}), 32'd0);
      check("rst credit cnt", 32'(dut.w_credit_cnt), 32'd4);

      // Three single-flit packets to fixed dest 1 with credit loopback
      cfg_dest = 2'd1; cfg_pkt_len = 4'd1; cfg_num_pkts = 16'd3;
      loopback = 1'b1; cfg_enable = 1'b1;
      for (int i = 0; i < 50 && !tx_done; i++) tick();
      check("t1 tx_done", 32'(tx_done), 32'd1);
      repeat (2) tick();
      check("t1 flit count", 32'(fq.size()), 32'd3);
      for (int i = 0; i < 3 && i < fq.size(); i++) begin
         check($sformatf("t1 data %0d", i), fq[i].d, 32'(i + 1));
         check($sformatf("t1 dest %0d", i), 32'(fq[i].dst), 32'd1);
         check($sformatf("t1 tail %0d", i), 32'(fq[i].tl), 32'd1);
      end
      check("t1 tx_pkt_count", 32'(tx_pkt_count), 32'd3);
      check("t1 credit cnt", 32'(dut.w_credit_cnt), 32'd4);
      cfg_enable = 1'b0;
      tick();
      check("t1 idle tx_done", 32'(tx_done), 32'd0);
      check("t1 idle pkt cnt clr", 32'(tx_pkt_count), 32'd0);

      // Credit starvation: 4-flit packets with credits held off
      do_reset();
      cfg_dest = 2'd1; cfg_pkt_len = 4'd4; cfg_num_pkts = 16'd2; cfg_enable = 1'b1;
      repeat (12) tick();
      check("t2 flits w/o credit", 32'(fq.size()), 32'd4);
      check("t2 stalled send_out", 32'(send_out), 32'd0);
      if (fq.size() >= 4) check("t2 flit4 tail", 32'({fq[3].tl, fq[2].tl}), 32'd2);
      for (int k = 0; k < 4; k++) begin
         base = fq.size();
         credit_in = 1'b1;
         tick();
         credit_in = 1'b0;
         repeat (3) tick();
         check($sformatf("t2 flits per credit %0d", k), 32'(fq.size() - base), 32'd1);
      end
      if (fq.size() == 8) begin
         check("t2 flit5 data", fq[4].d, 32'd5);
         check("t2 flit8 data", fq[7].d, 32'd8);
         check("t2 flit8 tail", 32'(fq[7].tl), 32'd1);
      end
      check("t2 tx_done", 32'(tx_done), 32'd1);
      check("t2 tx_pkt_count", 32'(tx_pkt_count), 32'd2);

      // Destination sweep 2,3,0,1,2 with per-destination sequence numbers
      do_reset();
      cfg_dest_mode = 1'b1; cfg_dest = 2'd2; cfg_pkt_len = 4'd2; cfg_num_pkts = 16'd5;
      loopback = 1'b1; cfg_enable = 1'b1;
      for (int i = 0; i < 100 && !tx_done; i++) tick();
      check("t3 tx_done", 32'(tx_done), 32'd1);
      repeat (2) tick();
      check("t3 flit count", 32'(fq.size()), 32'd10);
      for (int i = 0; i < 10 && i < fq.size(); i++) begin
         check($sformatf("t3 dest %0d", i), 32'(fq[i].dst), 32'(exp_d[i]));
         check($sformatf("t3 data %0d", i), fq[i].d, 32'(exp_s[i]));
         check($sformatf("t3 tail %0d", i), 32'(fq[i].tl), 32'(i % 2));
      end

      // Issue and credit return in the same cycle for 20 cycles
      do_reset();
      cfg_dest = 2'd1; cfg_pkt_len = 4'd4; cfg_num_pkts = 16'd5; cfg_enable = 1'b1;
      tick();
      credit_in = 1'b1;
      nflit = 0; bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (send_out) nflit++;
         if (dut.w_credit_cnt != 3'd4) bad++;
      end
      credit_in = 1'b0;
      check("t4 continuous flits", 32'(nflit), 32'd20);
      check("t4 credit cnt off-4 cycles", 32'(bad), 32'd0);
      tick();
      check("t4 stop after 20", 32'(send_out), 32'd0);
      check("t4 tx_done", 32'(tx_done), 32'd1);

      // RX checker
      do_reset();
      rx_flit(2'd1, 1, 2'd0, 1'b0);
      check("t5 credit_out f1", 32'(credit_out), 32'd1);
      check("t5 err_seq f1", 32'(err_seq), 32'd0);
      tick();
      check("t5 credit_out gap", 32'(credit_out), 32'd0);
      rx_flit(2'd1, 2, 2'd0, 1'b0);
      check("t5 credit_out f2", 32'(credit_out), 32'd1);
      check("t5 err_seq f2", 32'(err_seq), 32'd0);
      rx_flit(2'd1, 4, 2'd0, 1'b1);
      check("t5 credit_out f3", 32'(credit_out), 32'd1);
      check("t5 err_seq f3", 32'(err_seq), 32'd1);
      check("t5 err_dest f3", 32'(err_dest), 32'd0);
      check("t5 rx_pkt_count", 32'(rx_pkt_count), 32'd1);
      tick();
      check("t5 credit_out idle", 32'(credit_out), 32'd0);
      rx_flit(2'd1, 5, 2'd2, 1'b1);
      check("t5 err_dest", 32'(err_dest), 32'd1);
      check("t5 err_seq sticky", 32'(err_seq), 32'd1);
      check("t5 rx_pkt_count 2", 32'(rx_pkt_count), 32'd2);

      // Asynchronous reset in the middle of a packet
      do_reset();
      cfg_dest = 2'd1; cfg_pkt_len = 4'd4; cfg_num_pkts = 16'd0;
      loopback = 1'b1; cfg_enable = 1'b1;
      for (int i = 0; i < 20 && fq.size() < 2; i++) tick();
      check("t6 mid-packet reached", 32'(fq.size()), 32'd2);
      #3;
      rst_n = 1'b0;
      loopback = 1'b0; credit_in = 1'b0; cfg_enable = 1'b0;
      #1;
      check("t6 async send_out", 32'(send_out), 32'd0);
      check("t6 async data_out", data_out, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      fq.delete();
      check("t6 credit cnt", 32'(dut.w_credit_cnt), 32'd4);
      cfg_pkt_len = 4'd1; cfg_num_pkts = 16'd1;
      loopback = 1'b1; cfg_enable = 1'b1;
      for (int i = 0; i < 20 && fq.size() < 1; i++) tick();
      check("t6 post-reset flit", 32'(fq.size()), 32'd1);
      if (fq.size() > 0) check("t6 seq restarts", fq[0].d, 32'd1);
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/noc_traffic_endpoint.md
Name: noc_traffic_endpoint

Overview:
- Synthesisable credit-based traffic generator plus sink/checker. Attaches to one router input/output port pair.
- Replaces hand-written per-cycle bench stimulus with parametrised multi-flit packet generation, destination sweeping, credit tracking and in-order data checking.
- One instance per NoC endpoint in router and mesh benches. Also usable as on-chip BIST.

Parameters:
- NOC_NUM_ENDPOINTS, 2, number of endpoints; legal destinations are 0..NOC_NUM_ENDPOINTS-1.
- DEST_WIDTH, 1, width of destination field; must be at least clog2(NOC_NUM_ENDPOINTS).
- FLIT_WIDTH, 32, flit data width; must be greater than DEST_WIDTH+1.
- FLIT_BUFFER_DEPTH, 4, depth of the downstream router input buffer; this is the initial credit count.
- MAX_PKT_LEN, 8, maximum flits per packet.
- ENDPOINT_ID, 0, this endpoint's own address.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_enable  in  1  generator runs while high
- cfg_dest_mode  in  1  0 = fixed destination cfg_dest; 1 = destination increments per packet, wrapping at NOC_NUM_ENDPOINTS-1
- cfg_dest  in  DEST_WIDTH  fixed destination, and start destination in mode 1
- cfg_pkt_len  in  clog2(MAX_PKT_LEN+1)  flits per packet; 0 is treated as 1, values above MAX_PKT_LEN are clamped
- cfg_num_pkts  in  16  packets to send; 0 = unlimited
- data_out  out  FLIT_WIDTH  flit to router
- dest_out  out  DEST_WIDTH  flit destination
- is_tail_out  out  1  last flit of packet
- send_out  out  1  flit valid (single-cycle per flit)
- credit_in  in  1  credit returned by router, one per freed buffer slot
- data_in  in  FLIT_WIDTH  flit from router
- dest_in  in  DEST_WIDTH  received destination
- is_tail_in  in  1  received tail
- send_in  in  1  received flit valid
- credit_out  out  1  credit back to router
- tx_done  out  1  all cfg_num_pkts packets sent
- tx_pkt_count  out  16  packets sent
- rx_pkt_count  out  16  tails received
- err_seq  out  1  sticky sequence/source error
- err_dest  out  1  sticky misrouted-flit error

Behaviour:
- Reset: all outputs 0; credit_cnt = FLIT_BUFFER_DEPTH; all sequence counters 1; FSM in IDLE.
- Flit format:
  - data[FLIT_WIDTH-1 -: DEST_WIDTH] = ENDPOINT_ID.
  - Lower SEQ_WIDTH = FLIT_WIDTH-DEST_WIDTH bits = per-destination sequence number, starting at 1 and wrapping modulo 2^SEQ_WIDTH.
  - Each tx_seq[d] increments once per flit sent to destination d.
- Credit counter:
  - Width clog2(FLIT_BUFFER_DEPTH+1).
  - Next value = cnt - issue + credit_in; issue and credit_in in the same cycle leave it unchanged.
  - issue is allowed only when cnt > 0; credit_in arriving in the same cycle cannot enable an issue.
  - credit_in while cnt == FLIT_BUFFER_DEPTH (with no issue) is a protocol violation: saturate and fire a simulation assertion.
- TX FSM (states IDLE, SEND, DONE):
  - IDLE -> SEND when cfg_enable=1 and not all packets are sent. On this transition latch pkt_len and destination; dest_out is held constant for the whole packet.
  - SEND: each issue drives send_out=1 for one cycle with registered data_out/dest_out. is_tail_out=1 on flit pkt_len.
  - SEND, after the tail issues: increment tx_pkt_count; in mode 1, advance destination. Then:
    - -> DONE if tx_pkt_count has reached cfg_num_pkts (non-zero);
    - -> IDLE if cfg_enable=0;
    - otherwise stay in SEND and start the next packet on the next cycle with no bubble.
  - cfg_enable falling mid-packet does NOT stop the current packet; it finishes through its tail.
  - DONE: tx_done=1 until reset or until cfg_enable drops, which returns to IDLE and clears tx_pkt_count.
- Latency: one cycle from credits available and FSM in SEND to send_out high. Back-to-back flits are possible every cycle while credits last.
- RX side (always accepts; no backpressure):
  - credit_out is a registered copy of send_in: exactly one pulse, one cycle after each received flit.
  - On send_in: src = data_in upper field.
    - If src >= NOC_NUM_ENDPOINTS or the sequence field != rx_exp[src], set err_seq.
    - rx_exp[src] increments; after a mismatch it resynchronises to received value + 1.
    - dest_in != ENDPOINT_ID sets err_dest.
    - is_tail_in increments rx_pkt_count.
  - Error flags are sticky until reset.
- Reset mid-packet: outputs drop immediately (asynchronous). No partial-packet recovery is required.

Decomposition:
- Package noc_pkg:
  - flit field offsets;
  - SEQ_WIDTH function;
  - typedef tx_state_e {IDLE, SEND, DONE};
  - clog2-based width helpers, shared with router.
- Sub-module noc_credit_counter (params DEPTH, INIT): holds the credit count; inputs issue and credit_in; outputs has_credit and count. Reusable by the router output ports.

Test Plan:
- Reset, then cfg_enable=1, fixed dest 1, pkt_len 1, num_pkts 3, credit_in loopbacked from send_out one cycle later -> three single-flit tails with data 0x00000001..0x00000003 (ENDPOINT_ID=0); tx_done=1; tx_pkt_count=3.
- pkt_len 4, credit_in held 0 -> exactly 4 flits issued, then send_out stays low. Four single credit pulses follow -> the next 4 flits resume, with exactly one flit per credit.
- cfg_dest_mode 1, NOC_NUM_ENDPOINTS 4, cfg_dest 2, 5 packets of 2 flits -> destinations 2,3,0,1,2; per-destination sequence values continue (dest 2 second packet carries seq 3,4).
- Simultaneous issue and credit_in each cycle for 20 cycles -> credit_cnt stays 4, with 20 continuous flits.
- RX: inject src 1 flits with seq 1,2,4 -> err_seq set on the third flit only; credit_out pulses 3 times, each one cycle after send_in. Then inject dest_in != ENDPOINT_ID -> err_dest=1.
- Assert rst_n low mid-packet (flit 2 of 4) -> send_out=0 immediately; credit_cnt=4 and seq counters=1 after release.
